// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared widths, occupancy-state encoding and the operand-pair
// type used by approx_mul_arb and its sub-modules.
//   OP_W       operand width (32)
//   P_W        product width (64)
//   occ_e      pipeline occupancy, encoded as {v1, v2}
//   operand_t  operand pair {a, b}
//   rr_dist    round-robin distance of a requester index from the pointer
package approx_mul_pkg;

    localparam int OP_W = 32;
    localparam int P_W  = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        S2_ONLY = 2'b01,
        S1_ONLY = 2'b10,
        FULL    = 2'b11
    } occ_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

    // Search order starts just after the last winner: ptr+1 has distance 0,
    // ptr itself has distance n-1.
    function automatic int rr_dist(input int idx, input int ptr, input int n);
        return (idx > ptr) ? (idx - ptr - 1) : (idx + n - ptr - 1);
    endfunction

endpackage

// File: rtl/approx_mul_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i  request vector (N)
//   ptr_i  index of the previous winner; search starts at ptr_i+1 and wraps
//   en_i   grant enable; no grant when low
//   gnt_o  one-hot grant (N)
//   idx_o  binary index of the granted requester
module rr_arbiter
    import approx_mul_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] idx_o
);

    int best_dist;

    always_comb begin
        gnt_o     = '0;
        idx_o     = '0;
        best_dist = N;
        for (int j = 0; j < N; j++) begin
            if (en_i && req_i[j] && (rr_dist(j, int'(ptr_i), N) < best_dist)) begin
                best_dist = rr_dist(j, int'(ptr_i), N);
                gnt_o     = '0;
                gnt_o[j]  = 1'b1;
                idx_o     = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/radix4approx.sv
// radix4approx: unsigned 32x32 approximate multiplier.
//   a_i  operand A (32)
//   b_i  operand B (32), consumed as sixteen radix-4 digits
//   p_o  approximate product (64)
// Each radix-4 digit of B selects a partial product of 0, A or 2A. A digit of
// 3 is approximated as 2, removing the 3A adder; the result therefore never
// exceeds the exact product and always fits in 64 bits.
module radix4approx
    import approx_mul_pkg::*;
(
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    output logic [P_W-1:0]  p_o
);

    logic [P_W-1:0] pp;

    always_comb begin
        p_o = '0;
        pp  = '0;
        for (int i = 0; i < OP_W / 2; i++) begin
            case (b_i[2*i +: 2])
                2'd0:    pp = '0;
                2'd1:    pp = P_W'(a_i);
                default: pp = P_W'(a_i) << 1;
            endcase
            p_o = p_o + (pp << (2 * i));
        end
    end

endmodule

// File: rtl/approx_mul_arb.sv
// approx_mul_arb: round-robin arbiter and two-stage sequencer sharing one
// radix4approx multiplier among NREQ requesters.
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-requester operand handshake (ready is one-hot)
//   req_a, req_b          packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready   result handshake
//   rsp_id, rsp_p         owner index and 64-bit approximate product
//   busy                  either stage holds data
// Optional build macro MUL_ERR_MON_EN adds an exact multiplier and outputs
//   rsp_err   exact minus approximate product (64, two's complement)
//   err_cnt   saturating count of accepted responses with nonzero rsp_err
//
// state   | meaning
// EMPTY   | no operands, no result
// S1_ONLY | operands held in S1, no result presented
// S2_ONLY | result presented, S1 free
// FULL    | result presented and next operands waiting in S1
module approx_mul_arb
    import approx_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [P_W-1:0]       rsp_p,
    output logic                 busy
`ifdef MUL_ERR_MON_EN
    ,
    output logic [P_W-1:0]       rsp_err,
    output logic [31:0]          err_cnt
`endif
);

    occ_e            occ_q, occ_d;
    logic [OP_W-1:0] a_q, b_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] ptr_q;
    logic [P_W-1:0]  rsp_p_q;
    logic [ID_W-1:0] rsp_id_q;

    logic            v1, v2, v1_d, v2_d;
    logic            adv2, acc1, accept;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    operand_t        sel_op;
    logic [P_W-1:0]  mul_p;

    assign v1 = (occ_q == S1_ONLY) || (occ_q == FULL);
    assign v2 = (occ_q == S2_ONLY) || (occ_q == FULL);

    assign adv2   = v1 & (~v2 | rsp_ready);
    assign acc1   = ~v1 | adv2;
    assign accept = |gnt;

    rr_arbiter #(.N(NREQ), .ID_W(ID_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (acc1),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Grant is one-hot, so an OR of the gated slices is the selected pair.
    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op.a = sel_op.a | req_a[i*OP_W +: OP_W];
                sel_op.b = sel_op.b | req_b[i*OP_W +: OP_W];
            end
        end
    end

    radix4approx u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (mul_p)
    );

    // A draining result does not clear v2 when S1 refills S2 in the same cycle.
    always_comb begin
        v1_d  = accept ? 1'b1 : (adv2 ? 1'b0 : v1);
        v2_d  = adv2   ? 1'b1 : ((v2 & rsp_ready) ? 1'b0 : v2);
        occ_d = occ_e'({v1_d, v2_d});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= EMPTY;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            ptr_q    <= ID_W'(NREQ - 1);
            rsp_p_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (accept) begin
                a_q   <= sel_op.a;
                b_q   <= sel_op.b;
                id_q  <= gnt_idx;
                ptr_q <= gnt_idx;
            end
            if (adv2) begin
                rsp_p_q  <= mul_p;
                rsp_id_q <= id_q;
            end
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = v2;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = v1 | v2;

`ifdef MUL_ERR_MON_EN
    logic [P_W-1:0] exact_q;
    logic [31:0]    err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (adv2) begin
                exact_q <= P_W'(a_q) * P_W'(b_q);
            end
            if (rsp_valid && rsp_ready && (rsp_err != '0) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign rsp_err = exact_q - rsp_p_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mul_arb.sv
module tb_approx_mul_arb;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [63:0]       rsp_p;
    logic              busy;
`ifdef MUL_ERR_MON_EN
    logic [63:0]       rsp_err;
    logic [31:0]       err_cnt;
`endif

    approx_mul_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
`ifdef MUL_ERR_MON_EN
        ,
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the block behaves as a two-entry in-order queue; an
    // entry becomes visible on the response port two edges after acceptance.
    typedef struct {
        int          id;
        logic [63:0] p;
        logic [63:0] ex;
        int          cyc;
    } item_t;

    item_t       mq[$];
    int          mptr;
    int          cyc;
    int          err_m;
    logic [31:0] op_a [NREQ];
    logic [31:0] op_b [NREQ];
    int          dut_gnt;
    int          checks = 0;
    int          errors = 0;

    // Approximate product from arithmetic: each base-4 digit 3 of B counts as 2.
    function automatic logic [63:0] approx_ref(input logic [31:0] a, input logic [31:0] b);
        longint unsigned bb = 64'(b);
        longint unsigned bp = 0;
        longint unsigned w  = 1;
        longint unsigned d;
        for (int i = 0; i < 16; i++) begin
            d  = bb % 4;
            bb = bb / 4;
            bp = bp + ((d == 3) ? 2 : d) * w;
            w  = w * 4;
        end
        return 64'(a) * bp;
    endfunction

    function automatic logic [31:0] rnd_op();
        int s = $urandom_range(0, 9);
        if (s == 0) return 32'h0;
        if (s == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_p", rsp_p, 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
`ifdef MUL_ERR_MON_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_rsp_err", rsp_err, 64'd0);
`endif
        mq.delete();
        mptr  = NREQ - 1;
        err_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [NREQ-1:0] vmask, input logic rrdy, output int g);
        logic        vis;
        logic        pop;
        logic        can_acc;
        logic [NREQ-1:0] exp_rdy;
        item_t       it;
        @(negedge clk);
        req_valid = vmask;
        rsp_ready = rrdy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
        #1;
        vis     = (mq.size() > 0) && (mq[0].cyc + 1 < cyc);
        pop     = vis && rrdy;
        can_acc = (mq.size() < 2) || pop;
        g = -1;
        if (can_acc) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && vmask[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        dut_gnt = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_gnt = i;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(vis));
        chk("busy", 64'(busy), 64'(mq.size() > 0));
        if (vis) begin
            chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
            chk("rsp_p", rsp_p, mq[0].p);
`ifdef MUL_ERR_MON_EN
            chk("rsp_err", rsp_err, mq[0].ex - mq[0].p);
`endif
        end
`ifdef MUL_ERR_MON_EN
        chk("err_cnt", 64'(err_cnt), 64'(err_m));
`endif
        if (pop) begin
            if (mq[0].ex != mq[0].p) err_m++;
            void'(mq.pop_front());
        end
        if (g >= 0) begin
            it.id  = g;
            it.p   = approx_ref(op_a[g], op_b[g]);
            it.ex  = 64'(op_a[g]) * 64'(op_b[g]);
            it.cyc = cyc;
            mq.push_back(it);
            mptr = g;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n_acc;
        logic [NREQ-1:0] pend;
        cyc = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        do_reset();

        // Single request from requester 2
        op_a[2] = 32'd3;
        op_b[2] = 32'd5;
        step(4'b0100, 1'b1, g);
        chk("single_grant", 64'(dut_gnt), 64'd2);
        step(4'b0000, 1'b1, g);
        chk("single_valid", 64'(rsp_valid), 64'd1);
        chk("single_id", 64'(rsp_id), 64'd2);
        chk("single_p", rsp_p, 64'd15);
        step(4'b0000, 1'b1, g);

        // Zero operand
        op_a[1] = 32'h0;
        op_b[1] = 32'hFFFF_FFFF;
        step(4'b0010, 1'b1, g);
        step(4'b0000, 1'b1, g);
        chk("zero_valid", 64'(rsp_valid), 64'd1);
        chk("zero_p", rsp_p, 64'd0);
        step(4'b0000, 1'b1, g);

        // All requesters continuously valid from a fresh pointer
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1, g);
            chk("rr_order", 64'(dut_gnt), 64'(i % NREQ));
        end
        repeat (3) step(4'b0000, 1'b1, g);

        // Backpressure: exactly two products absorbed, then drained in order
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, g);
            if (dut_gnt >= 0) n_acc++;
        end
        chk("bp_accepts", 64'(n_acc), 64'd2);
        repeat (4) step(4'b0000, 1'b1, g);

        // Mid-operation reset while FULL
        repeat (2) step(4'b1111, 1'b0, g);
        chk("full_before_rst", 64'(busy), 64'd1);
        do_reset();
        step(4'b1111, 1'b1, g);
        chk("post_rst_grant", 64'(dut_gnt), 64'd0);
        repeat (3) step(4'b0000, 1'b1, g);

        // Randomised traffic with held requests and random backpressure
        pend = '0;
        for (int n = 0; n < 1200; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = 1'b1;
                    op_a[i] = rnd_op();
                    op_b[i] = rnd_op();
                end
            end
            step(pend, ($urandom_range(0, 99) < 75), g);
            if (g >= 0) pend[g] = 1'b0;
        end
        repeat (4) step(4'b0000, 1'b1, g);
        chk("drained_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
